// File: rtl/servo_angle_ramp.sv
// Multi-channel servo angle ramp: each channel slews its angle toward an
// open/closed target by at most STEP per shared tick, pulsing done on arrival.
module servo_angle_ramp #(
  parameter int CHANNELS     = 2,
  parameter int ANGLE_W      = 9,
  parameter int OPEN_ANGLE   = 220,
  parameter int CLOSED_ANGLE = 0,
  parameter int STEP         = 4,
  parameter int TICK_DIV     = 100000
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        cmd_valid,
  input  logic [2:0]                  cmd_chan,
  input  logic [31:0]                 servoControl,
  output logic                        cmd_ready,
  output logic                        cmd_err,
  output logic [CHANNELS*ANGLE_W-1:0] angle,
  output logic [CHANNELS-1:0]         busy,
  output logic [CHANNELS-1:0]         done
);

  localparam int CNT_W = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0]   CNT_MAX  = CNT_W'(TICK_DIV - 1);
  localparam logic [ANGLE_W-1:0] OPEN_A   = OPEN_ANGLE[ANGLE_W-1:0];
  localparam logic [ANGLE_W-1:0] CLOSED_A = CLOSED_ANGLE[ANGLE_W-1:0];
  localparam logic [ANGLE_W:0]   STEP_X   = STEP[ANGLE_W:0];

  typedef enum logic {IDLE = 1'b0, RAMP = 1'b1} state_t;

  logic [CNT_W-1:0]   cnt_reg;
  logic               tick;
  logic               accept;
  logic               bad_chan;
  logic [3:0]         chan_x;
  logic [ANGLE_W-1:0] target_cmd;
  logic               cmd_err_reg;

  assign cmd_ready  = ~reset;
  assign accept     = cmd_valid & cmd_ready;
  assign chan_x     = {1'b0, cmd_chan};
  assign bad_chan   = chan_x >= 4'(CHANNELS);
  assign target_cmd = (servoControl == 32'd1) ? OPEN_A : CLOSED_A;
  assign tick       = (cnt_reg == CNT_MAX);
  assign cmd_err    = cmd_err_reg;

  // Shared tick counter; every channel steps on the same edges.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_reg     <= '0;
      cmd_err_reg <= 1'b0;
    end else begin
      cnt_reg     <= tick ? '0 : cnt_reg + 1'b1;
      cmd_err_reg <= accept & bad_chan;
    end
  end

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
    state_t             state_reg, state_next;
    logic [ANGLE_W-1:0] angle_reg, angle_next;
    logic [ANGLE_W-1:0] target_reg, target_next;
    logic               done_reg, done_next;
    logic               hit;
    logic [ANGLE_W:0]   up_sum, dn_val;
    logic [ANGLE_W-1:0] stepped;

    assign hit = accept && (cmd_chan == 3'(gi));

    // One extra bit catches overflow above the target and underflow below zero.
    always_comb begin
      up_sum = {1'b0, angle_reg} + STEP_X;
      dn_val = {1'b0, angle_reg} - STEP_X;
      if (target_reg > angle_reg) begin
        stepped = (up_sum >= {1'b0, target_reg}) ? target_reg : up_sum[ANGLE_W-1:0];
      end else begin
        stepped = (dn_val[ANGLE_W] || (dn_val[ANGLE_W-1:0] <= target_reg))
                  ? target_reg : dn_val[ANGLE_W-1:0];
      end
    end

    // A command on this channel takes priority over a coincident tick step.
    always_comb begin
      state_next  = state_reg;
      angle_next  = angle_reg;
      target_next = target_reg;
      done_next   = 1'b0;
      if (hit) begin
        target_next = target_cmd;
        if (target_cmd == angle_reg) begin
          state_next = IDLE;
          done_next  = 1'b1;
        end else begin
          state_next = RAMP;
        end
      end else if ((state_reg == RAMP) && tick) begin
        angle_next = stepped;
        if (stepped == target_reg) begin
          state_next = IDLE;
          done_next  = 1'b1;
        end
      end
    end

    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        state_reg  <= IDLE;
        angle_reg  <= CLOSED_A;
        target_reg <= CLOSED_A;
        done_reg   <= 1'b0;
      end else begin
        state_reg  <= state_next;
        angle_reg  <= angle_next;
        target_reg <= target_next;
        done_reg   <= done_next;
      end
    end

    assign angle[gi*ANGLE_W +: ANGLE_W] = angle_reg;
    assign busy[gi]                     = (state_reg == RAMP);
    assign done[gi]                     = done_reg;
  end

endmodule

// File: tb/tb_servo_angle_ramp.sv
// Directed bench for servo_angle_ramp with TICK_DIV=4, STEP=50, two channels.
module tb_servo_angle_ramp;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        cmd_valid = 1'b0;
  logic [2:0]  cmd_chan = 3'd0;
  logic [31:0] servoControl = 32'd0;
  logic        cmd_ready;
  logic        cmd_err;
  logic [17:0] angle;
  logic [1:0]  busy;
  logic [1:0]  done;

  int checks = 0;
  int errors = 0;

  servo_angle_ramp #(
    .CHANNELS(2), .ANGLE_W(9), .OPEN_ANGLE(220), .CLOSED_ANGLE(0),
    .STEP(50), .TICK_DIV(4)
  ) dut (
    .clock(clock), .reset(reset), .cmd_valid(cmd_valid), .cmd_chan(cmd_chan),
    .servoControl(servoControl), .cmd_ready(cmd_ready), .cmd_err(cmd_err),
    .angle(angle), .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic send(input int ch, input logic [31:0] sc);
    cmd_valid    = 1'b1;
    cmd_chan     = 3'(ch);
    servoControl = sc;
  endtask

  // Advance one clock, release the command strobe, check all outputs.
  task automatic step(input int a0, input int a1, input logic [1:0] b,
                      input logic [1:0] d, input logic e);
    @(posedge clock);
    #1;
    cmd_valid = 1'b0;
    chk("angle0", 32'(angle[8:0]), a0);
    chk("angle1", 32'(angle[17:9]), a1);
    chk("busy", 32'(busy), 32'(b));
    chk("done", 32'(done), 32'(d));
    chk("cmd_err", 32'(cmd_err), 32'(e));
  endtask

  task automatic run(input int n, input int a0, input int a1, input logic [1:0] b);
    repeat (n) step(a0, a1, b, 2'b00, 1'b0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    chk("rst_ready", 32'(cmd_ready), 0);
    chk("rst_angle", 32'(angle), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_err", 32'(cmd_err), 0);
    @(posedge clock);
    #1;
    chk("rst_hold_done", 32'(done), 0);
    chk("rst_hold_busy", 32'(busy), 0);
    reset = 1'b0;
    #1;
    chk("ready_after_rst", 32'(cmd_ready), 1);
  endtask

  initial begin
    #1;
    do_reset();

    // Open ch0: 50,100,150,200,220 on ticks every 4 clocks
    send(0, 32'd1);
    step(0, 0, 2'b01, 2'b00, 1'b0);
    run(2, 0, 0, 2'b01);
    run(4, 50, 0, 2'b01);
    run(4, 100, 0, 2'b01);
    run(4, 150, 0, 2'b01);
    run(4, 200, 0, 2'b01);
    step(220, 0, 2'b00, 2'b01, 1'b0);
    step(220, 0, 2'b00, 2'b00, 1'b0);

    // ch1 at 0 told to close (value 7): no motion, done next cycle
    send(1, 32'd7);
    step(220, 0, 2'b00, 2'b10, 1'b0);
    step(220, 0, 2'b00, 2'b00, 1'b0);

    // Out-of-range channel: one-cycle error, nothing else changes
    send(2, 32'd1);
    step(220, 0, 2'b00, 2'b00, 1'b1);
    step(220, 0, 2'b00, 2'b00, 1'b0);

    // Close ch0 from 220 (value with bit 0 set but not equal to 1)
    send(0, 32'h8000_0001);
    step(220, 0, 2'b01, 2'b00, 1'b0);
    run(1, 220, 0, 2'b01);
    run(4, 170, 0, 2'b01);
    run(4, 120, 0, 2'b01);
    run(4, 70, 0, 2'b01);
    run(4, 20, 0, 2'b01);
    step(0, 0, 2'b00, 2'b01, 1'b0);
    step(0, 0, 2'b00, 2'b00, 1'b0);

    // Retarget to closed while ch0 sits at 100
    do_reset();
    send(0, 32'd1);
    step(0, 0, 2'b01, 2'b00, 1'b0);
    run(2, 0, 0, 2'b01);
    run(4, 50, 0, 2'b01);
    run(1, 100, 0, 2'b01);
    send(0, 32'd0);
    step(100, 0, 2'b01, 2'b00, 1'b0);
    run(2, 100, 0, 2'b01);
    run(4, 50, 0, 2'b01);
    step(0, 0, 2'b00, 2'b01, 1'b0);
    step(0, 0, 2'b00, 2'b00, 1'b0);

    // Asynchronous reset while ch0 at 150
    do_reset();
    send(0, 32'd1);
    step(0, 0, 2'b01, 2'b00, 1'b0);
    run(2, 0, 0, 2'b01);
    run(4, 50, 0, 2'b01);
    run(4, 100, 0, 2'b01);
    run(1, 150, 0, 2'b01);
    do_reset();

    // Both channels open; ch1 command lands on a tick edge and does not step
    send(0, 32'd1);
    step(0, 0, 2'b01, 2'b00, 1'b0);
    run(2, 0, 0, 2'b01);
    send(1, 32'd1);
    step(50, 0, 2'b11, 2'b00, 1'b0);
    run(3, 50, 0, 2'b11);
    run(4, 100, 50, 2'b11);
    run(4, 150, 100, 2'b11);
    run(4, 200, 150, 2'b11);
    step(220, 200, 2'b10, 2'b01, 1'b0);
    run(3, 220, 200, 2'b10);
    step(220, 220, 2'b00, 2'b10, 1'b0);
    step(220, 220, 2'b00, 2'b00, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
